computer_tx_framer: RTL and testbench

//   Return path to the host PC: accepts 32-bit response words and sends each as 4 UART bytes,

---
 rtl/computer_tx_pkg.sv | 41 ++++
 rtl/computer_baud_tick.sv | 48 ++++
 rtl/computer_tx_framer.sv | 143 ++++++++++++++
 tb/tb_computer_tx_framer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/computer_tx_pkg.sv
// rtl/computer_tx_pkg.sv - shared states, baud table and divisor helper for the host TX framer
// Optional even-parity bit is enabled by COMPUTER_TX_PARITY_EN (see computer_tx_framer).
package computer_tx_pkg;

  // One-hot state codes; PARITY keeps its code even when the parity bit is compiled out.
  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_START  = 5'b00010;
  localparam logic [4:0] ST_DATA   = 5'b00100;
  localparam logic [4:0] ST_PARITY = 5'b01000;
  localparam logic [4:0] ST_STOP   = 5'b10000;

  typedef enum logic [4:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

  localparam int DIV_W = 24;

  function automatic int baud_of(input logic [2:0] code);
    case (code)
      3'd0:    return 9600;
      3'd1:    return 19200;
      3'd2:    return 38400;
      3'd3:    return 57600;
      3'd4:    return 115200;
      3'd5:    return 230400;
      3'd6:    return 460800;
      default: return 921600;
    endcase
  endfunction

  function automatic int div_of(input int clk_freq, input logic [2:0] code);
    int baud;
    baud = baud_of(code);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/computer_baud_tick.sv
// rtl/computer_baud_tick.sv - bit-period timer; latches the divisor on accept and ticks every DIV cycles
module computer_baud_tick
  import computer_tx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       run,
  input  logic [2:0] baud_set,
  output logic       bit_tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_sel;

  // Every entry is elaborated from constants, so no run-time divider is built.
  always_comb begin
    div_sel = DIV_W'(div_of(CLK_FREQ, 3'd7));
    case (baud_set)
      3'd0:    div_sel = DIV_W'(div_of(CLK_FREQ, 3'd0));
      3'd1:    div_sel = DIV_W'(div_of(CLK_FREQ, 3'd1));
      3'd2:    div_sel = DIV_W'(div_of(CLK_FREQ, 3'd2));
      3'd3:    div_sel = DIV_W'(div_of(CLK_FREQ, 3'd3));
      3'd4:    div_sel = DIV_W'(div_of(CLK_FREQ, 3'd4));
      3'd5:    div_sel = DIV_W'(div_of(CLK_FREQ, 3'd5));
      3'd6:    div_sel = DIV_W'(div_of(CLK_FREQ, 3'd6));
      default: div_sel = DIV_W'(div_of(CLK_FREQ, 3'd7));
    endcase
  end

  assign bit_tick = run && (cnt == div_q - DIV_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= DIV_W'(div_of(CLK_FREQ, 3'd0));
      cnt   <= '0;
    end else if (start) begin
      div_q <= div_sel;
      cnt   <= '0;
    end else if (run) begin
      cnt <= bit_tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/computer_tx_framer.sv
// rtl/computer_tx_framer.sv - sends 32-bit response words to the host as 4 UART bytes, MSB byte first
// Define COMPUTER_TX_PARITY_EN to append an even-parity bit to every byte.
module computer_tx_framer
  import computer_tx_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_valid,
  input  logic [31:0] tx_data,
  output logic        tx_ready,
  input  logic [2:0]  baud_set,
  output logic        uart_tx,
  output logic        busy,
  output logic        tx_done
);

  localparam logic STOP_LAST = (STOP_BITS == 2);

  state_t      state;
  logic [31:0] word;
  logic [7:0]  sh;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic        stop_idx;
  logic        accept;
  logic        bit_tick;
`ifdef COMPUTER_TX_PARITY_EN
  logic        par;
`endif

  assign accept = tx_valid && tx_ready;

  computer_baud_tick #(
    .CLK_FREQ(CLK_FREQ)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept),
    .run     (busy),
    .baud_set(baud_set),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      word     <= '0;
      sh       <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      stop_idx <= 1'b0;
`ifdef COMPUTER_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            word     <= tx_data;
            sh       <= tx_data[31:24];
`ifdef COMPUTER_TX_PARITY_EN
            par      <= ^tx_data[31:24];
`endif
            byte_idx <= '0;
            state    <= START;
            uart_tx  <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            state   <= DATA;
            uart_tx <= sh[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == 3'd7) begin
`ifdef COMPUTER_TX_PARITY_EN
              state    <= PARITY;
              uart_tx  <= par;
`else
              state    <= STOP;
              uart_tx  <= 1'b1;
              stop_idx <= 1'b0;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              sh      <= {1'b0, sh[7:1]};
              uart_tx <= sh[1];
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state    <= STOP;
            uart_tx  <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (stop_idx != STOP_LAST) begin
              stop_idx <= 1'b1;
            end else if (byte_idx == 2'd3) begin
              state    <= IDLE;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              // Next byte starts straight after the stop bit, no idle gap.
              byte_idx <= byte_idx + 2'd1;
              word     <= {word[23:0], 8'h00};
              sh       <= word[23:16];
`ifdef COMPUTER_TX_PARITY_EN
              par      <= ^word[23:16];
`endif
              state    <= START;
              uart_tx  <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          uart_tx  <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_computer_tx_framer.sv
// tb/tb_computer_tx_framer.sv - scoreboard bench: stimulus queues expected bytes/word times, monitors decode uart_tx
module tb_computer_tx_framer;
  import computer_tx_pkg::*;

`ifdef COMPUTER_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BYTE_BITS = 10 + PAR;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tx_valid = 1'b0;
  logic [31:0] tx_data = '0;
  logic [2:0]  baud_set = '0;
  logic        tx_ready, uart_tx, busy, tx_done;

  computer_tx_framer #(.CLK_FREQ(50_000_000), .STOP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .baud_set(baud_set), .uart_tx(uart_tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         first;
    bit         skip;
  } exp_t;

  exp_t byte_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   word_start = 0;
  int   last_done_cyc = -1;
  int   passed = 0;
  int   total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Byte monitor: detects a start bit and samples each bit at its centre.
  initial begin
    exp_t       e;
    logic [7:0] got;
    logic       start_ok, stop_ok, par_bit;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && reset_n) begin
        if (byte_q.size() == 0) begin
          chk("unexpected_start", 1, 0);
          while (uart_tx === 1'b0) @(negedge clk);
        end else begin
          e = byte_q.pop_front();
          if (e.first) word_start = cyc;
          repeat (e.div / 2) @(negedge clk);
          start_ok = (uart_tx === 1'b0);
          for (int i = 0; i < 8; i++) begin
            repeat (e.div) @(negedge clk);
            got[i] = uart_tx;
          end
          par_bit = 1'b0;
          if (PAR == 1) begin
            repeat (e.div) @(negedge clk);
            par_bit = uart_tx;
          end
          repeat (e.div) @(negedge clk);
          stop_ok = (uart_tx === 1'b1);
          if (!e.skip) begin
            chk("byte_data", got, e.data);
            chk("byte_frame", {start_ok, stop_ok}, 2'b11);
            if (PAR == 1) chk("parity_bit", par_bit, ^e.data);
          end
        end
      end
    end
  end

  // Word monitor: tx_done timing relative to the first start-bit cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        last_done_cyc = cyc;
        chk("done_flags", {tx_ready, busy}, 2'b10);
        if (done_q.size() == 0) chk("unexpected_tx_done", 1, 0);
        else chk("word_time", cyc - word_start, done_q.pop_front());
      end
    end
  end

  // mode 0: full word; mode 1: reset will abandon it during byte 2.
  task automatic send(input logic [31:0] w, input logic [2:0] code, input int div,
                      input int mode, input bit keep_valid);
    int n = 0;
    tx_data  = w;
    baud_set = code;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60000) chk("ready_timeout", 0, 1);
    for (int b = 0; b < 4; b++) begin
      exp_t e;
      e.data  = w[31 - 8*b -: 8];
      e.div   = div;
      e.first = (b == 0);
      e.skip  = (mode == 1 && b == 2);
      if (!(mode == 1 && b == 3)) byte_q.push_back(e);
    end
    if (mode == 0) done_q.push_back(4 * BYTE_BITS * div);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) tx_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((done_q.size() != 0 || busy === 1'b1) && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60000) chk("drain_timeout", 0, 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int err;
    logic [31:0] divs [8];
    divs = '{5208, 2604, 1302, 868, 434, 217, 109, 54};
    for (int i = 0; i < 8; i++) chk($sformatf("div_of_%0d", i), div_of(50_000_000, 3'(i)), divs[i]);

    // 1. reset and idle
    repeat (3) @(negedge clk);
    chk("reset_outputs", {uart_tx, tx_ready, busy, tx_done}, 4'b1100);
    reset_n = 1'b1;
    err = 0;
    repeat (100) begin
      @(negedge clk);
      if ({uart_tx, tx_ready, busy, tx_done} !== 4'b1100) err++;
    end
    chk("idle_outputs", err, 0);

    // 2. single word at 115200
    send(32'hA55A0FF0, 3'd4, 434, 0, 1'b0);
    chk("busy_in_word", {busy, tx_ready, uart_tx}, 3'b100);
    wait_drained();

    // 3. back-to-back at 921600
    send(32'h00000001, 3'd7, 54, 0, 1'b1);
    tx_data = 32'hFFFFFFFF;
    send(32'hFFFFFFFF, 3'd7, 54, 0, 1'b0);
    chk("b2b_accept_on_done", cyc - last_done_cyc, 1);
    chk("b2b_start_bit", uart_tx, 1'b0);
    wait_drained();

    // 4. baud and data changes mid-word are ignored
    send(32'hDEADBEEF, 3'd3, 868, 0, 1'b0);
    repeat (5000) @(negedge clk);
    baud_set = 3'd7;
    tx_data  = 32'h00000000;
    wait_drained();
    send(32'h3C6996C3, 3'd7, 54, 0, 1'b0);
    wait_drained();

    // 5. reset during byte 2 data bits
    send(32'hC381007E, 3'd6, 109, 1, 1'b0);
    repeat (2 * 10 * 109 + 4 * 109 + 50) @(negedge clk);
    chk("pre_reset_line", {uart_tx, busy}, 2'b01);
    #2 reset_n = 1'b0;
    #1 chk("reset_line_immediate", {uart_tx, tx_ready, busy, tx_done}, 4'b1100);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (1200) @(negedge clk);
    chk("no_done_after_abort", last_done_cyc < word_start, 1);
    send(32'h12345678, 3'd6, 109, 0, 1'b0);
    wait_drained();

`ifdef COMPUTER_TX_PARITY_EN
    // 6. parity bits 1,0,1,0
    send(32'h01030700, 3'd4, 434, 0, 1'b0);
    wait_drained();
`endif

    repeat (20) @(negedge clk);
    chk("byte_queue_empty", byte_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
